// File: rtl/fp2int_pkg.sv
// Shared constants and types for the single-precision to int32 converter.
//   EXP_BIAS / EXP_SPECIAL : IEEE-754 single exponent bias and the all-ones exponent
//   INT_MAX / INT_MIN      : saturation values of the signed 32-bit result
//   state_t                : sequencer state encoding
//   cls_t                  : special-case classes produced by fp2int_classify
package fp2int_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned EXP_W  = 8;
   localparam int unsigned FRAC_W = 23;
   localparam int unsigned CNT_W  = 5;

   localparam logic [EXP_W-1:0] EXP_BIAS    = EXP_W'(127);
   localparam logic [EXP_W-1:0] EXP_SPECIAL = EXP_W'(255);
   // Biased exponent at which {1,frac} already sits at integer weight (e == 23).
   localparam logic [EXP_W-1:0] EXP_ALIGN   = EXP_W'(150);
   // Biased exponent for e == 31: first magnitude that no longer fits in int32.
   localparam logic [EXP_W-1:0] EXP_LIMIT   = EXP_W'(158);

   localparam logic [DATA_W-1:0] INT_MAX = 32'h7FFF_FFFF;
   localparam logic [DATA_W-1:0] INT_MIN = 32'h8000_0000;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CHECK = 3'd1,
      ST_SHIFT = 3'd2,
      ST_SIGN  = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   typedef enum logic [2:0] {
      CLS_NORMAL = 3'd0,
      CLS_NAN    = 3'd1,
      CLS_SAT    = 3'd2,
      CLS_ZERO   = 3'd3,
      CLS_MIN    = 3'd4
   } cls_t;

   // Saturated value for an out-of-range operand of the given sign.
   function automatic logic [DATA_W-1:0] sat_value(input logic sign);
      return sign ? INT_MIN : INT_MAX;
   endfunction

endpackage

// File: rtl/fp2int_classify.sv
// Combinational classifier for a captured single-precision operand.
// Ports:
//   sign, exp, frac : operand fields
//   cls             : special-case class (CLS_NORMAL when the shifter is needed)
//   shift_cnt       : |e - 23|, valid for CLS_NORMAL
//   shift_left      : 1 when e > 23, valid for CLS_NORMAL
module fp2int_classify
   import fp2int_pkg::*;
(
   input  logic                sign,
   input  logic [EXP_W-1:0]    exp,
   input  logic [FRAC_W-1:0]   frac,
   output cls_t                cls,
   output logic [CNT_W-1:0]    shift_cnt,
   output logic                shift_left
);

   // Priority order: NaN, infinity, |x| < 1, exactly -2^31, overflow, normal.
   always_comb begin
      cls        = CLS_NORMAL;
      shift_cnt  = '0;
      shift_left = 1'b0;
      if (exp == EXP_SPECIAL) begin
         cls = (frac != '0) ? CLS_NAN : CLS_SAT;
      end else if (exp < EXP_BIAS) begin
         cls = CLS_ZERO;
      end else if ((exp == EXP_LIMIT) && sign && (frac == '0)) begin
         cls = CLS_MIN;
      end else if (exp >= EXP_LIMIT) begin
         cls = CLS_SAT;
      end else if (exp > EXP_ALIGN) begin
         shift_left = 1'b1;
         shift_cnt  = CNT_W'(exp - EXP_ALIGN);
      end else begin
         shift_cnt  = CNT_W'(EXP_ALIGN - exp);
      end
   end

endmodule

// File: rtl/fp2int.sv
// Multi-cycle IEEE-754 single to signed int32 converter, truncating toward zero.
// The mantissa is shifted one bit per cycle into integer position, then negated
// if needed. Special operands finish in one cycle after start.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   start, a   : load operand a and begin (aborts any conversion in flight)
//   result     : signed integer result, held until next start/reset
//   done       : result valid
//   overflow   : result saturated
//   invalid    : operand was NaN
module fp2int
   import fp2int_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [DATA_W-1:0] a,
   output logic [DATA_W-1:0] result,
   output logic              done,
   output logic              overflow,
   output logic              invalid
);

   state_t              state_q, state_d;
   logic                sign_q, sign_d;
   logic [EXP_W-1:0]    exp_q, exp_d;
   logic [DATA_W-1:0]   mag_q, mag_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                left_q, left_d;
   logic [DATA_W-1:0]   result_q, result_d;
   logic                done_q, done_d;
   logic                ovf_q, ovf_d;
   logic                inv_q, inv_d;

   cls_t                cls;
   logic [CNT_W-1:0]    cls_cnt;
   logic                cls_left;

   // Classify from the captured fields; the fraction lives in the low mag bits.
   fp2int_classify u_classify (
      .sign       (sign_q),
      .exp        (exp_q),
      .frac       (mag_q[FRAC_W-1:0]),
      .cls        (cls),
      .shift_cnt  (cls_cnt),
      .shift_left (cls_left)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; start restarts from any state.
   always_comb begin
      state_d = state_q;
      if (start) begin
         state_d = ST_CHECK;
      end else begin
         case (state_q)
            ST_CHECK: begin
               if (cls != CLS_NORMAL) begin
                  state_d = ST_DONE;
               end else if (cls_cnt == '0) begin
                  state_d = ST_SIGN;
               end else begin
                  state_d = ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (cnt_q == CNT_W'(1)) begin
                  state_d = ST_SIGN;
               end
            end
            ST_SIGN:  state_d = ST_DONE;
            default:  state_d = state_q;
         endcase
      end
   end

   // Datapath and output next values.
   always_comb begin
      sign_d   = sign_q;
      exp_d    = exp_q;
      mag_d    = mag_q;
      cnt_d    = cnt_q;
      left_d   = left_q;
      result_d = result_q;
      done_d   = done_q;
      ovf_d    = ovf_q;
      inv_d    = inv_q;
      if (start) begin
         sign_d = a[DATA_W-1];
         exp_d  = a[DATA_W-2:FRAC_W];
         mag_d  = {(DATA_W-FRAC_W-1)'(0), 1'b1, a[FRAC_W-1:0]};
         cnt_d  = '0;
         left_d = 1'b0;
         done_d = 1'b0;
         ovf_d  = 1'b0;
         inv_d  = 1'b0;
      end else begin
         case (state_q)
            ST_CHECK: begin
               cnt_d  = cls_cnt;
               left_d = cls_left;
               case (cls)
                  CLS_NAN: begin
                     result_d = INT_MIN;
                     inv_d    = 1'b1;
                     done_d   = 1'b1;
                  end
                  CLS_SAT: begin
                     result_d = sat_value(sign_q);
                     ovf_d    = 1'b1;
                     done_d   = 1'b1;
                  end
                  CLS_ZERO: begin
                     result_d = '0;
                     done_d   = 1'b1;
                  end
                  CLS_MIN: begin
                     result_d = INT_MIN;
                     done_d   = 1'b1;
                  end
                  default: ;
               endcase
            end
            ST_SHIFT: begin
               mag_d = left_q ? (mag_q << 1) : (mag_q >> 1);
               cnt_d = cnt_q - CNT_W'(1);
            end
            ST_SIGN: begin
               result_d = sign_q ? (~mag_q + DATA_W'(1)) : mag_q;
               done_d   = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Datapath and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         sign_q   <= 1'b0;
         exp_q    <= '0;
         mag_q    <= '0;
         cnt_q    <= '0;
         left_q   <= 1'b0;
         result_q <= '0;
         done_q   <= 1'b0;
         ovf_q    <= 1'b0;
         inv_q    <= 1'b0;
      end else begin
         sign_q   <= sign_d;
         exp_q    <= exp_d;
         mag_q    <= mag_d;
         cnt_q    <= cnt_d;
         left_q   <= left_d;
         result_q <= result_d;
         done_q   <= done_d;
         ovf_q    <= ovf_d;
         inv_q    <= inv_d;
      end
   end

   assign result   = result_q;
   assign done     = done_q;
   assign overflow = ovf_q;
   assign invalid  = inv_q;

endmodule

// File: tb/tb_fp2int.sv
// Bench for fp2int: directed operands with hand-derived answers, then random
// operands checked against an arithmetic reference model.
module tb_fp2int;

   logic        clk;
   logic        reset;
   logic        start;
   logic [31:0] a;
   logic [31:0] result;
   logic        done;
   logic        overflow;
   logic        invalid;

   int vectors = 0;
   int errors  = 0;

   fp2int dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .a        (a),
      .result   (result),
      .done     (done),
      .overflow (overflow),
      .invalid  (invalid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Reference: value = (-1)^s * 1.frac * 2^e, truncated, then range-clamped.
   task automatic model(input logic [31:0] op, output logic [31:0] r,
                        output logic ovf, output logic inv, output int lat);
      int     ex;
      int     e;
      longint mag;
      longint v;
      ex  = int'(op[30:23]);
      e   = ex - 127;
      ovf = 1'b0;
      inv = 1'b0;
      lat = 1;
      if (ex == 255) begin
         if (op[22:0] != 23'd0) begin
            inv = 1'b1;
            r   = 32'h8000_0000;
         end else begin
            ovf = 1'b1;
            r   = op[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
         end
      end else if (e < 0) begin
         r = 32'd0;
      end else begin
         mag = longint'({1'b1, op[22:0]});
         if (e > 40)       mag = 64'sd1 <<< 62;
         else if (e >= 23) mag = mag <<< (e - 23);
         else              mag = mag >>> (23 - e);
         v = op[31] ? -mag : mag;
         if (v > 64'sd2147483647) begin
            ovf = 1'b1;
            r   = 32'h7FFF_FFFF;
         end else if (v < -64'sd2147483648) begin
            ovf = 1'b1;
            r   = 32'h8000_0000;
         end else begin
            r = 32'(v);
         end
         if (e < 31) lat = (e > 23 ? e - 23 : 23 - e) + 2;
      end
   endtask

   // Count edges until done rises, then check latency, outputs and hold.
   task automatic wait_done(input string tag, input logic [31:0] er, input logic eo,
                            input logic ei, input int elat);
      int lat;
      logic [31:0] held;
      lat = 0;
      while (done !== 1'b1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, ".lat"}, 32'(lat), 32'(elat));
      chk({tag, ".res"}, result, er);
      chk({tag, ".ovf"}, 32'(overflow), 32'(eo));
      chk({tag, ".inv"}, 32'(invalid), 32'(ei));
      held = result;
      repeat (3) @(posedge clk);
      #1;
      chk({tag, ".hold"}, {result[31:1], result[0] ^ ~done}, {held[31:1], held[0]});
   endtask

   // Issue a start with op; a is scrambled afterwards since it must be ignored.
   task automatic convert(input string tag, input logic [31:0] op, input logic [31:0] er,
                          input logic eo, input logic ei, input int elat);
      @(negedge clk);
      start = 1'b1;
      a     = op;
      @(posedge clk); #1;
      start = 1'b0;
      a     = $urandom;
      chk({tag, ".clr"}, 32'({done, overflow, invalid}), 32'd0);
      wait_done(tag, er, eo, ei, elat);
   endtask

   typedef struct {
      logic [31:0] op;
      logic [31:0] res;
      logic        ovf;
      logic        inv;
      int          lat;
   } vec_t;

   vec_t dir[11];

   initial begin
      logic [31:0] op, er;
      logic        eo, ei;
      int          el;
      int          seen;

      dir[0]  = '{32'h3F80_0000, 32'h0000_0001, 1'b0, 1'b0, 25};
      dir[1]  = '{32'hC020_0000, 32'hFFFF_FFFE, 1'b0, 1'b0, 24};
      dir[2]  = '{32'h4EFF_FFFF, 32'h7FFF_FF80, 1'b0, 1'b0, 9};
      dir[3]  = '{32'h4B00_0000, 32'h0080_0000, 1'b0, 1'b0, 2};
      dir[4]  = '{32'hCF00_0000, 32'h8000_0000, 1'b0, 1'b0, 1};
      dir[5]  = '{32'h4F00_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1};
      dir[6]  = '{32'hFF80_0000, 32'h8000_0000, 1'b1, 1'b0, 1};
      dir[7]  = '{32'h7FC0_0000, 32'h8000_0000, 1'b0, 1'b1, 1};
      dir[8]  = '{32'h3F00_0000, 32'h0000_0000, 1'b0, 1'b0, 1};
      dir[9]  = '{32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0, 1};
      dir[10] = '{32'hBF00_0000, 32'h0000_0000, 1'b0, 1'b0, 1};

      reset = 1'b1;
      start = 1'b0;
      a     = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst.res", result, 32'd0);
      chk("rst.flags", 32'({done, overflow, invalid}), 32'd0);
      reset = 1'b0;

      // Nothing happens without start, even with a changing.
      repeat (5) begin
         a = $urandom;
         @(posedge clk);
      end
      #1;
      chk("idle.done", 32'(done), 32'd0);

      foreach (dir[i])
         convert($sformatf("dir%0d", i), dir[i].op, dir[i].res, dir[i].ovf, dir[i].inv, dir[i].lat);

      // Reset on edge 5 of a conversion: outputs cleared, no done afterwards.
      @(negedge clk);
      start = 1'b1;
      a     = 32'h3F80_0000;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("rstmid.res", result, 32'd0);
      chk("rstmid.flags", 32'({done, overflow, invalid}), 32'd0);
      seen = 0;
      repeat (30) begin
         @(posedge clk); #1;
         if (done === 1'b1) seen++;
      end
      chk("rstmid.nodone", 32'(seen), 32'd0);

      // Restart on edge 3 of a conversion with 3.0.
      @(negedge clk);
      start = 1'b1;
      a     = 32'h3F80_0000;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk);
      #1;
      start = 1'b1;
      a     = 32'h4040_0000;
      @(posedge clk); #1;
      start = 1'b0;
      a     = $urandom;
      chk("abort.clr", 32'(done), 32'd0);
      wait_done("abort", 32'h0000_0003, 1'b0, 1'b0, 24);

      // Random operands, biased toward exponents around the integer range.
      for (int k = 0; k < 150; k++) begin
         op = $urandom;
         if (k % 4 != 0) op[30:23] = 8'($urandom_range(118, 162));
         if (k % 25 == 0) op[30:23] = 8'hFF;
         model(op, er, eo, ei, el);
         convert($sformatf("rnd%0d_%h", k, op), op, er, eo, ei, el);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/fp2int.md
FP2INT -- requirements
Module: fp2int

Interface
REQ-001 SHALL have no parameters; fixed to IEEE-754 single precision in and signed 32-bit two's-complement out.
REQ-002 SHALL expose ports:
- clk  input  1  sole clock, rising edge
- reset  input  1  synchronous, active-high
- start  input  1  sampled each rising edge; high loads a new operand
- a  input  32  IEEE-754 single operand {sign, exp[7:0], frac[22:0]}, sampled only on a start edge
- result  output  32  signed integer, registered
- done  output  1  registered; high when result is valid
- overflow  output  1  registered; saturated-result flag
- invalid  output  1  registered; NaN-input flag

Function
REQ-003 SHALL convert with truncation toward zero; unbiased exponent e = exp - 127.
REQ-004 SHALL use states IDLE, CHECK, SHIFT, SIGN, DONE.
REQ-005 On a start edge SHALL capture sign/exp/mant = {1, frac} into a 32-bit magnitude register right-aligned, clear done/overflow/invalid, and enter CHECK.
REQ-006 SHALL apply these CHECK outcomes, highest priority first; each special case enters DONE and sets result/flags:
- exp == 255 with frac != 0: invalid=1, result 0x8000_0000
- exp == 255 with frac == 0: overflow=1, result 0x7FFF_FFFF if positive, 0x8000_0000 if negative
- exp < 127 (zero, denormal, |x| < 1): result 0x0000_0000, no flag
- e == 31 with sign=1 and frac == 0: result 0x8000_0000, no flag
- e >= 31 otherwise: overflow=1, saturated as above
- else: shift count n = |e - 23| and direction (left if e > 23, right if e < 23); enter SHIFT if n > 0, else SIGN.
REQ-007 SHIFT SHALL shift magnitude one bit per cycle in the chosen direction, decrement n, and exit to SIGN on the edge where n reaches 0; right-shifted-out bits are discarded.
REQ-008 SIGN SHALL write result = sign ? (~mag + 1) : mag, set done=1, and enter DONE.
REQ-009 Latency, counted in rising edges after the start edge: special cases 1 edge; normal cases n + 2 edges, where 0 <= n <= 23, for a maximum of 25.
REQ-010 DONE SHALL hold result, done and flags stable until the next start or reset.
REQ-011 A start during CHECK/SHIFT/SIGN SHALL abort the current conversion and restart with the new operand; done stays 0.
REQ-012 A start in DONE SHALL clear done on that edge and begin a new conversion.
REQ-013 Changes on a while start is low SHALL have no effect.
REQ-014 Negative zero and negative values with |x| < 1 SHALL produce 0x0000_0000, never 0x8000_0000.

Reset
REQ-015 On reset high at a rising edge: state=IDLE, result=0, done=0, overflow=0, invalid=0, magnitude and count cleared.
REQ-016 Reset SHALL take priority over a simultaneous start.
REQ-017 Reset mid-conversion SHALL discard the operation with no done pulse.
REQ-018 IDLE SHALL be left only via start.

Structure
REQ-019 A shared package SHALL hold EXP_BIAS=127, EXP_SPECIAL=255, INT_MAX=0x7FFF_FFFF, INT_MIN=0x8000_0000, and the state encoding.
REQ-020 A combinational sub-module fp2int_classify SHALL take {sign, exp, frac} and return special-case class, shift count and direction; the sequencer and datapath SHALL stay in fp2int.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- a=0x3F80_0000 (1.0) -> result 0x0000_0001, done exactly 25 edges after start, no flags.
- a=0xC020_0000 (-2.5) -> result 0xFFFF_FFFE (-2), done 24 edges after start.
- a=0x4EFF_FFFF -> result 0x7FFF_FF80 with left shift n=7, done 9 edges after start; a=0x4B00_0000 -> 0x0080_0000 (n=0), done 2 edges after start.
- a=0xCF00_0000 -> 0x8000_0000, overflow=0; a=0x4F00_0000 -> 0x7FFF_FFFF, overflow=1; a=0xFF80_0000 -> 0x8000_0000, overflow=1.
- a=0x7FC0_0000 -> 0x8000_0000, invalid=1, done 1 edge after start; a=0x3F00_0000 and a=0x8000_0000 -> 0x0000_0000.
- start(1.0), then reset on edge 5 -> no done, all outputs 0; start(1.0), then start(0x4040_0000) on edge 3 -> result 0x0000_0003, done 24 edges after the second start.
